pipeline_ctrl: RTL

Central pipeline sequencer for the five-stage MIPS datapath. It drives the `Ld`/`Clr` pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It resolves three conditions: load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It also runs a post-reset flush sequence and a memory-timeout fault state.

---
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the five-stage MIPS datapath: load-use stalls, branch flushes,
// data-memory waits, post-reset flush and memory-timeout fault. Define PIPE_CTRL_PERF_EN for live perf counters.
module pipeline_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegDstData,
  input  logic        EX_BranchTaken,
  input  logic        MEM_MemAccess,
  input  logic        MEM_Ready,
  output logic        PCWrite,
  output logic        IF_ID_Ld,
  output logic        IF_ID_Clr,
  output logic        ID_EX_Ld,
  output logic        ID_EX_Clr,
  output logic        EX_MEM_Ld,
  output logic        EX_MEM_Clr,
  output logic        MEM_WB_Ld,
  output logic        MEM_WB_Clr,
  output logic        MemFault,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {StInit, StRun, StWait, StFault} StateT;

  StateT         state, nextState;
  logic [IW-1:0] initCnt;
  logic [WW-1:0] waitCnt;
  logic          active, memWait, loadUse;

  assign active  = (state == StRun) || (state == StWait);
  assign memWait = MEM_MemAccess && !MEM_Ready;
  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign loadUse = EX_MemRead && (EX_RegDstData != 5'd0) &&
                   ((EX_RegDstData == ID_Rs) || (ID_UsesRt && (EX_RegDstData == ID_Rt)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= StInit;
      initCnt <= '0;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (state == StInit) initCnt <= initCnt + 1'b1;
      if (active) waitCnt <= memWait ? waitCnt + 1'b1 : '0;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      StInit:  if (initCnt == INIT_LAST) nextState = StRun;
      StRun,
      StWait: begin
        if (memWait) nextState = (TIMEOUT_EN && waitCnt == WAIT_LAST) ? StFault : StWait;
        else         nextState = StRun;
      end
      StFault: nextState = StFault;
      default: nextState = StInit;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IF_ID_Ld   = 1'b0;  IF_ID_Clr  = 1'b0;
    ID_EX_Ld   = 1'b0;  ID_EX_Clr  = 1'b0;
    EX_MEM_Ld  = 1'b0;  EX_MEM_Clr = 1'b0;
    MEM_WB_Ld  = 1'b0;  MEM_WB_Clr = 1'b0;
    MemFault   = 1'b0;
    case (state)
      StInit: begin
        IF_ID_Clr = 1'b1; ID_EX_Clr = 1'b1; EX_MEM_Clr = 1'b1; MEM_WB_Clr = 1'b1;
      end
      StRun,
      StWait: begin
        if (memWait) begin
          // Bubble into WB so the frozen MEM instruction does not write back twice.
          MEM_WB_Clr = 1'b1;
        end else if (EX_BranchTaken) begin
          PCWrite   = 1'b1;
          IF_ID_Ld  = 1'b1; ID_EX_Ld  = 1'b1; EX_MEM_Ld = 1'b1; MEM_WB_Ld = 1'b1;
          IF_ID_Clr = 1'b1; ID_EX_Clr = 1'b1;
        end else if (loadUse) begin
          ID_EX_Clr = 1'b1; EX_MEM_Ld = 1'b1; MEM_WB_Ld = 1'b1;
        end else begin
          PCWrite   = 1'b1;
          IF_ID_Ld  = 1'b1; ID_EX_Ld  = 1'b1; EX_MEM_Ld = 1'b1; MEM_WB_Ld = 1'b1;
        end
      end
      StFault: MemFault = 1'b1;
      default: ;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stallInc, flushInc;
  assign stallInc = active && (memWait || (!EX_BranchTaken && loadUse));
  assign flushInc = active && !memWait && EX_BranchTaken;

  // Counters saturate rather than wrap so long runs stay monotonic.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (stallInc && StallCycles != 32'hFFFF_FFFF) StallCycles <= StallCycles + 32'd1;
      if (flushInc && FlushCount  != 32'hFFFF_FFFF) FlushCount  <= FlushCount  + 32'd1;
    end
  end
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule
